// File: rtl/min_max_input_ctrl.sv
// Board-side front end for the min/max LED bar. It synchronizes the buttons and switches,
// edits min/max/val under a target FSM, and generates the osc blink square wave.
module min_max_input_ctrl #(
  parameter int unsigned VALSIZE  = 4,
  parameter int unsigned OSC_HALF = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [1:0]         com_sw_i,
  input  logic               sel_i,
  input  logic               up_i,
  input  logic               down_i,
  output logic [1:0]         com_o,
  output logic [VALSIZE-1:0] min_o,
  output logic [VALSIZE-1:0] max_o,
  output logic [VALSIZE-1:0] val_o,
  output logic               osc_o,
  output logic [1:0]         target_o
);

  localparam int unsigned CNT_W = 16;
  localparam logic [VALSIZE-1:0] VAL_ONES = '1;
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(OSC_HALF - 1);

  typedef enum logic [1:0] {
    T_MIN = 2'b00,
    T_MAX = 2'b01,
    T_VAL = 2'b10
  } target_t;

  target_t            target;
  logic [4:0]         sync1;    // {com_sw[1:0], sel, up, down}
  logic [2:0]         sync2;    // {sel, up, down}
  logic [2:0]         prev;
  logic [1:0]         warm;
  logic [CNT_W-1:0]   osc_cnt;
  logic               ev_en;
  logic               sel_ev;
  logic               up_ev;
  logic               down_ev;

  // Events are masked until prev holds a real sample, so a button held through reset never fires.
  assign ev_en   = (warm == 2'd3);
  assign sel_ev  = ev_en & sync2[2] & ~prev[2];
  assign up_ev   = ev_en & sync2[1] & ~prev[1];
  assign down_ev = ev_en & sync2[0] & ~prev[0];

  assign target_o = target;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync1   <= '0;
      sync2   <= '0;
      prev    <= '0;
      warm    <= '0;
      com_o   <= '0;
      min_o   <= '0;
      max_o   <= VAL_ONES;
      val_o   <= '0;
      osc_cnt <= '0;
      osc_o   <= 1'b0;
      target  <= T_MIN;
    end else begin
      sync1 <= {com_sw_i, sel_i, up_i, down_i};
      sync2 <= sync1[2:0];
      com_o <= sync1[4:3];
      prev  <= sync2;
      if (warm != 2'd3) warm <= warm + 2'd1;

      // Free-running blink: toggle on each counter wrap.
      if (osc_cnt == CNT_LAST) begin
        osc_cnt <= '0;
        osc_o   <= ~osc_o;
      end else begin
        osc_cnt <= osc_cnt + CNT_W'(1);
      end

      // Conflicting up+down in one cycle cancel; edits use the pre-advance target.
      if (up_ev && !down_ev) begin
        case (target)
          T_MIN:   if (min_o < max_o)    min_o <= min_o + VALSIZE'(1);
          T_MAX:   if (max_o != VAL_ONES) max_o <= max_o + VALSIZE'(1);
          T_VAL:   if (val_o != VAL_ONES) val_o <= val_o + VALSIZE'(1);
          default: ;
        endcase
      end else if (down_ev && !up_ev) begin
        case (target)
          T_MIN:   if (min_o != '0)      min_o <= min_o - VALSIZE'(1);
          T_MAX:   if (max_o > min_o)    max_o <= max_o - VALSIZE'(1);
          T_VAL:   if (val_o != '0)      val_o <= val_o - VALSIZE'(1);
          default: ;
        endcase
      end

      if (sel_ev) begin
        case (target)
          T_MIN:   target <= T_MAX;
          T_MAX:   target <= T_VAL;
          default: target <= T_MIN;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_min_max_input_ctrl.sv
// Directed bench for min_max_input_ctrl (VALSIZE=4, OSC_HALF=8) with hand-computed expectations.
module tb_min_max_input_ctrl;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] com_sw_i;
  logic       sel_i;
  logic       up_i;
  logic       down_i;
  logic [1:0] com_o;
  logic [3:0] min_o;
  logic [3:0] max_o;
  logic [3:0] val_o;
  logic       osc_o;
  logic [1:0] target_o;

  int checks = 0;
  int errors = 0;

  min_max_input_ctrl #(.VALSIZE(4), .OSC_HALF(8)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .com_sw_i (com_sw_i),
    .sel_i    (sel_i),
    .up_i     (up_i),
    .down_i   (down_i),
    .com_o    (com_o),
    .min_o    (min_o),
    .max_o    (max_o),
    .val_o    (val_o),
    .osc_o    (osc_o),
    .target_o (target_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Advance n rising edges, then settle 1 time unit past the edge.
  task automatic step(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic pulse(input logic s, input logic u, input logic d);
    sel_i = s; up_i = u; down_i = d;
    step(4);
    sel_i = 1'b0; up_i = 1'b0; down_i = 1'b0;
    step(4);
  endtask

  initial begin
    rst_i = 1'b1; com_sw_i = 2'b00; sel_i = 1'b0; up_i = 1'b0; down_i = 1'b0;
    step(3);
    rst_i = 1'b0;
    check("rst_min", 32'(min_o), 32'd0);
    check("rst_max", 32'(max_o), 32'd15);
    check("rst_val", 32'(val_o), 32'd0);
    check("rst_target", 32'(target_o), 32'd0);
    check("rst_com", 32'(com_o), 32'd0);
    check("rst_osc", 32'(osc_o), 32'd0);

    // osc: rises at edge 8, falls at 16, rises again at 24
    step(7);  check("osc_e7", 32'(osc_o), 32'd0);
    step(1);  check("osc_e8", 32'(osc_o), 32'd1);
    step(7);  check("osc_e15", 32'(osc_o), 32'd1);
    step(1);  check("osc_e16", 32'(osc_o), 32'd0);
    step(8);  check("osc_e24", 32'(osc_o), 32'd1);
    step(16);
    check("idle_min", 32'(min_o), 32'd0);
    check("idle_max", 32'(max_o), 32'd15);
    check("idle_val", 32'(val_o), 32'd0);
    check("idle_target", 32'(target_o), 32'd0);
    check("idle_com", 32'(com_o), 32'd0);

    // com latency: two edges
    com_sw_i = 2'b10;
    step(1); check("com_lat1", 32'(com_o), 32'd0);
    step(1); check("com_lat2", 32'(com_o), 32'd2);
    com_sw_i = 2'b01;
    step(2); check("com_01", 32'(com_o), 32'd1);
    com_sw_i = 2'b00;
    step(2);

    // sel latency: new target exactly on the 3rd edge after the rise
    begin
      logic [1:0] exp_t [3];
      exp_t[0] = 2'b01; exp_t[1] = 2'b10; exp_t[2] = 2'b00;
      for (int i = 0; i < 3; i++) begin
        logic [1:0] old_t;
        old_t = (i == 0) ? 2'b00 : exp_t[i-1];
        sel_i = 1'b1;
        step(2); check("sel_early", 32'(target_o), 32'(old_t));
        step(1); check("sel_land", 32'(target_o), 32'(exp_t[i]));
        step(1);
        sel_i = 1'b0;
        step(4);
      end
    end

    // VALUE saturation both ways
    pulse(1, 0, 0); pulse(1, 0, 0);
    check("to_value", 32'(target_o), 32'd2);
    for (int i = 1; i <= 17; i++) begin
      pulse(0, 1, 0);
      if (i == 15) check("val_up15", 32'(val_o), 32'd15);
    end
    check("val_up17", 32'(val_o), 32'd15);
    for (int i = 1; i <= 16; i++) pulse(0, 0, 1);
    check("val_down16", 32'(val_o), 32'd0);

    // min = max = 5, bounds hold
    pulse(1, 0, 0);
    check("to_min", 32'(target_o), 32'd0);
    for (int i = 0; i < 5; i++) pulse(0, 1, 0);
    check("min_5", 32'(min_o), 32'd5);
    pulse(1, 0, 0);
    for (int i = 0; i < 12; i++) pulse(0, 0, 1);
    check("max_floor", 32'(max_o), 32'd5);
    pulse(1, 0, 0); pulse(1, 0, 0);
    pulse(0, 1, 0);
    check("min_ceiling", 32'(min_o), 32'd5);
    pulse(1, 0, 0);
    pulse(0, 0, 1);
    check("max_stay5", 32'(max_o), 32'd5);
    pulse(0, 1, 0);
    check("max_6", 32'(max_o), 32'd6);

    // up+down together cancel
    pulse(1, 0, 0);
    for (int i = 0; i < 7; i++) pulse(0, 1, 0);
    check("val_7", 32'(val_o), 32'd7);
    pulse(0, 1, 1);
    check("updown_cancel", 32'(val_o), 32'd7);

    // sel+up together: edit old target (MIN), then advance, same edge
    pulse(1, 0, 0);
    for (int i = 0; i < 5; i++) pulse(0, 0, 1);
    check("min_0", 32'(min_o), 32'd0);
    sel_i = 1'b1; up_i = 1'b1;
    step(2);
    check("selup_early_min", 32'(min_o), 32'd0);
    check("selup_early_tgt", 32'(target_o), 32'd0);
    step(1);
    check("selup_min", 32'(min_o), 32'd1);
    check("selup_tgt", 32'(target_o), 32'd1);
    step(1);
    sel_i = 1'b0; up_i = 1'b0;
    step(4);
    check("selup_max", 32'(max_o), 32'd6);

    // held button: one increment only
    pulse(1, 0, 0);
    check("to_value2", 32'(target_o), 32'd2);
    pulse(0, 1, 0);
    check("val_8", 32'(val_o), 32'd8);
    up_i = 1'b1;
    step(50);
    check("hold_once", 32'(val_o), 32'd9);
    up_i = 1'b0;
    step(4);

    // asynchronous reset mid-cycle, release with up held
    @(posedge clk_i);
    #2;
    rst_i = 1'b1;
    #1;
    check("arst_val", 32'(val_o), 32'd0);
    check("arst_osc", 32'(osc_o), 32'd0);
    check("arst_min", 32'(min_o), 32'd0);
    check("arst_max", 32'(max_o), 32'd15);
    check("arst_target", 32'(target_o), 32'd0);
    up_i = 1'b1;
    step(3);
    rst_i = 1'b0;
    step(20);
    check("held_at_release", 32'(val_o), 32'd0);
    up_i = 1'b0;
    step(4);
    check("held_release_end", 32'(val_o), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
